// File: rtl/instruction_queue.sv
// instruction_queue: fetch-to-decode FIFO with opcode tap; define INSTRUCTION_QUEUE_BYPASS_EN for empty-queue bypass
// Ports: clk, rst (sync, active-high), flush; in_valid/ins_in/in_ready (fetch side); out_valid/out_ready/ins_out/opcode (decode side); count (entries held)
module instruction_queue #(
  parameter int INS_W = 10,
  parameter int DEPTH = 4,
  parameter int OPC_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [INS_W-1:0]           ins_in,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INS_W-1:0]           ins_out,
  output logic [OPC_W-1:0]           opcode,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [INS_W-1:0] mem_q [DEPTH];
  logic [INS_W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic empty, byp, push, pop, st_push, st_pop;
  logic [INS_W-1:0] byp_word;
  assign empty = count_q == '0;
`ifdef INSTRUCTION_QUEUE_BYPASS_EN
  assign byp      = empty & in_valid & ~flush;
  assign byp_word = ins_in;
`else
  assign byp      = 1'b0;
  assign byp_word = '0;
`endif
  assign in_ready  = (count_q < CW'(DEPTH)) & ~flush;
  assign out_valid = (~empty & ~flush) | byp;
  assign ins_out   = ~out_valid ? '0 : empty ? byp_word : mem_q[rd_q];
  assign opcode    = ins_out[INS_W-1 -: OPC_W];
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // A bypassed word taken in the same cycle never touches storage
  assign st_push   = push & ~(byp & out_ready);
  assign st_pop    = pop & ~byp;
  always_comb begin
    mem_d = mem_q;
    if (st_push) mem_d[wr_q] = ins_in;
    wr_d    = flush ? '0 : st_push ? wr_q + AW'(1) : wr_q;
    rd_d    = flush ? '0 : st_pop ? rd_q + AW'(1) : rd_q;
    count_d = flush ? '0 : count_q + CW'(st_push) - CW'(st_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed stimulus with scoreboard queue and independent output monitor
module tb_instruction_queue;
  logic clk = 0, rst, flush, in_valid, out_ready, in_ready, out_valid;
  logic [9:0] ins_in, ins_out;
  logic [3:0] opcode;
  logic [2:0] count;
  int ntests = 0, nfail = 0;
  logic [9:0] exp_q[$];

  instruction_queue #(.INS_W(10), .DEPTH(4), .OPC_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .ins_in(ins_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .ins_out(ins_out), .opcode(opcode), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [9:0] d, input logic ordy, input logic fl);
    in_valid = iv;
    ins_in = d;
    out_ready = ordy;
    flush = fl;
  endtask

  // Monitor: every handshake presented to the decoder must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      ntests++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL pop_order: got 0x%0h expected nothing", ins_out);
      end else begin
        if (ins_out != exp_q[0]) begin
          nfail++;
          $display("FAIL pop_order: got 0x%0h expected 0x%0h", ins_out, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [9:0] fill_w[4];
    fill_w = '{10'h3A1, 10'h102, 10'h2F3, 10'h004};
    rst = 1;
    drive(0, 0, 0, 0);
    tick;
    rst = 0;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ins_out", ins_out, 0);
    chk("rst_opcode", opcode, 0);

    for (int i = 0; i < 4; i++) begin
      drive(1, fill_w[i], 0, 0);
      exp_q.push_back(fill_w[i]);
      tick;
    end
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_ins_out", ins_out, 10'h3A1);
    chk("fill_opcode", opcode, 4'hE);
    drive(1, 10'h155, 0, 0);
    tick;
    chk("overflow_count", count, 4);
    chk("overflow_head", ins_out, 10'h3A1);

    drive(0, 0, 1, 0);
    tick;
    tick;
    chk("drain2_count", count, 2);
    drive(1, 10'h0AA, 0, 0);
    exp_q.push_back(10'h0AA);
    tick;
    drive(1, 10'h0BB, 0, 0);
    exp_q.push_back(10'h0BB);
    tick;
    chk("wrap_count", count, 4);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick;
    chk("drained_count", count, 0);
    chk("drained_out_valid", out_valid, 0);
    chk("drained_ins_out", ins_out, 0);

    drive(1, 10'h011, 0, 0);
    exp_q.push_back(10'h011);
    tick;
    drive(1, 10'h022, 0, 0);
    exp_q.push_back(10'h022);
    tick;
    for (int i = 0; i < 5; i++) begin
      drive(1, 10'h031 + 10'(i), 1, 0);
      exp_q.push_back(10'h031 + 10'(i));
      tick;
      chk("simul_count", count, 2);
    end
    drive(0, 0, 1, 0);
    tick;
    tick;
    chk("simul_drain_count", count, 0);

    for (int i = 0; i < 3; i++) begin
      drive(1, 10'h301 + 10'(i), 0, 0);
      tick;
    end
    chk("preflush_count", count, 3);
    drive(1, 10'h1FF, 1, 1);
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_out_valid_same", out_valid, 0);
    tick;
    drive(0, 0, 1, 0);
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    tick;
    tick;

    drive(1, 10'h2C5, 1, 0);
    exp_q.push_back(10'h2C5);
    #1;
`ifdef INSTRUCTION_QUEUE_BYPASS_EN
    chk("byp_out_valid", out_valid, 1);
    chk("byp_ins_out", ins_out, 10'h2C5);
    tick;
    drive(0, 0, 1, 0);
    chk("byp_count", count, 0);
    chk("byp_after_valid", out_valid, 0);
`else
    chk("nobyp_out_valid", out_valid, 0);
    chk("nobyp_ins_out", ins_out, 0);
    tick;
    drive(0, 0, 1, 0);
    chk("nobyp_next_valid", out_valid, 1);
    chk("nobyp_next_ins", ins_out, 10'h2C5);
    tick;
    chk("nobyp_count", count, 0);
`endif

    drive(1, 10'h3C3, 0, 0);
    tick;
    drive(1, 10'h3C4, 0, 0);
    tick;
    chk("mid_count", count, 2);
    rst = 1;
    drive(1, 10'h3C5, 1, 1);
    tick;
    rst = 0;
    drive(0, 0, 1, 0);
    chk("midrst_count", count, 0);
    chk("midrst_out_valid", out_valid, 0);
    tick;
    tick;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
